chipram_bank_sequencer: RTL and testbench



---
 rtl/chipram_bank_pkg.sv | 31 +++
 rtl/bank_seq_timer.sv | 28 ++
 rtl/chipram_bank_sequencer.sv | 151 +++++++++++++++
 tb/tb_chipram_bank_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chipram_bank_pkg.sv
// Shared definitions for the chip-RAM bank sequencer: op codes, sequencer states,
// register map constants and command normalisation.
package chipram_bank_pkg;

  localparam int NUMBANKS_DEF = 16;

  localparam logic [8:0] REG_BANKC  = 9'h1E0;
  localparam logic [8:0] REG_STATUS = 9'h1E2;
  localparam logic [8:0] REG_CONFIG = 9'h1E4;

  typedef enum logic [1:0] {
    OP_DSBNK   = 2'b00,
    OP_CNBNK   = 2'b01,
    OP_RPBNK   = 2'b10,
    OP_ILLEGAL = 2'b11
  } bank_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_SAFE = 2'b01,
    ST_BREAK     = 2'b10,
    ST_MAKE      = 2'b11
  } seq_state_e;

  // Illegal ops and out-of-range banks fall back to disconnect, like the BANKC decode.
  function automatic logic [1:0] norm_op(logic [1:0] op, logic [3:0] bank, int nb);
    if (op == OP_ILLEGAL || int'(bank) >= nb) return OP_DSBNK;
    return op;
  endfunction

endpackage

// File: rtl/bank_seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module bank_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                       count_d = load_val;
    else if (en && count_q != '0)   count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/chipram_bank_sequencer.sv
// Applies BANKC bank-switch commands to the active-low BANKSEL lines inside
// chip-bus-idle slots, with break-before-make dead time and soft-reset handling.
module chipram_bank_sequencer
  import chipram_bank_pkg::*;
#(
  parameter int NUMBANKS     = NUMBANKS_DEF,
  parameter int DEAD_CYCLES  = 2,
  parameter int SAFE_TIMEOUT = 255
) (
  input  logic                CCK,
  input  logic                RST,
  input  logic                SOFT_RST,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [1:0]          CMD_OP,
  input  logic [3:0]          CMD_BANK,
  input  logic                SAFE,
  output logic [NUMBANKS-1:0] BANKSEL,
  output logic [1:0]          CUR_MODE,
  output logic [3:0]          CUR_BANK,
  output logic                BUSY,
  output logic                TIMEOUT_ERR
);

  seq_state_e          state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [3:0]          bank_q, bank_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          cbank_q, cbank_d;
  logic [NUMBANKS-1:0] bsel_q, bsel_d;
  logic                terr_q, terr_d;
  logic                spend_q, spend_d;

  logic                tmr_load, tmr_en, tmr_done;
  logic [7:0]          tmr_val;
  logic [1:0]          in_op;
  logic                cmd_ready, same_cmd, soft_go;
  logic [NUMBANKS-1:0] sel_mk;

  bank_seq_timer #(.W(8)) u_timer (
    .clk      (CCK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    sel_mk = '1;
    for (int i = 0; i < NUMBANKS; i++) sel_mk[i] = (int'(cbank_q) != i);
  end

  always_comb begin
    in_op     = norm_op(CMD_OP, CMD_BANK, NUMBANKS);
    same_cmd  = (in_op == OP_DSBNK) ? (mode_q == OP_DSBNK)
                                    : (in_op == mode_q && CMD_BANK == cbank_q);
    // A pending soft reset against a CN bank must run before any new command.
    soft_go   = (SOFT_RST || spend_q) && (mode_q == OP_CNBNK);
    cmd_ready = (state_q == ST_IDLE) && !RST && !SOFT_RST && !soft_go;

    state_d  = state_q;
    op_d     = op_q;
    bank_d   = bank_q;
    mode_d   = mode_q;
    cbank_d  = cbank_q;
    bsel_d   = bsel_q;
    terr_d   = terr_q;
    spend_d  = spend_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = 8'd0;

    if (state_q != ST_IDLE && SOFT_RST) spend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        spend_d = 1'b0;
        if (soft_go) begin
          op_d     = OP_DSBNK;
          state_d  = ST_WAIT_SAFE;
          tmr_load = 1'b1;
          tmr_val  = 8'(SAFE_TIMEOUT - 1);
        end else if (CMD_VALID && cmd_ready) begin
          op_d   = in_op;
          bank_d = CMD_BANK;
          if (!same_cmd) begin
            state_d  = ST_WAIT_SAFE;
            tmr_load = 1'b1;
            tmr_val  = 8'(SAFE_TIMEOUT - 1);
          end
        end
      end
      ST_WAIT_SAFE: begin
        tmr_en = 1'b1;
        if (SAFE || tmr_done) begin
          // SAFE in the timeout cycle still counts as a clean switch.
          if (!SAFE) terr_d = 1'b1;
          state_d  = ST_BREAK;
          tmr_load = 1'b1;
          tmr_val  = 8'(DEAD_CYCLES - 1);
          bsel_d   = '1;
          mode_d   = op_q;
          if (op_q != OP_DSBNK) cbank_d = bank_q;
        end
      end
      ST_BREAK: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          if (op_q == OP_DSBNK) state_d = ST_IDLE;
          else begin
            state_d = ST_MAKE;
            bsel_d  = sel_mk;
          end
        end
      end
      ST_MAKE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CCK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DSBNK;
      bank_q  <= 4'd0;
      mode_q  <= OP_DSBNK;
      cbank_q <= 4'd0;
      bsel_q  <= '1;
      terr_q  <= 1'b0;
      spend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
      mode_q  <= mode_d;
      cbank_q <= cbank_d;
      bsel_q  <= bsel_d;
      terr_q  <= terr_d;
      spend_q <= spend_d;
    end
  end

  assign CMD_READY   = cmd_ready;
  assign BANKSEL     = bsel_q;
  assign CUR_MODE    = mode_q;
  assign CUR_BANK    = cbank_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_chipram_bank_sequencer.sv
// Directed bench for chipram_bank_sequencer: 16-bank main instance plus an
// 8-bank instance on the same inputs for the out-of-range bank decode.
module tb_chipram_bank_sequencer;

  logic        CCK = 1'b0;
  logic        RST, SOFT_RST, CMD_VALID, SAFE;
  logic [1:0]  CMD_OP;
  logic [3:0]  CMD_BANK;
  logic        CMD_READY, BUSY, TIMEOUT_ERR;
  logic [15:0] BANKSEL;
  logic [1:0]  CUR_MODE;
  logic [3:0]  CUR_BANK;
  logic        rdy8, busy8, terr8;
  logic [7:0]  bsel8;
  logic [1:0]  mode8;
  logic [3:0]  bank8;

  int n_tests = 0;
  int n_fail  = 0;
  int nc, no;

  always #5 CCK = ~CCK;

  chipram_bank_sequencer #(.NUMBANKS(16), .DEAD_CYCLES(2), .SAFE_TIMEOUT(8)) dut (
    .CCK(CCK), .RST(RST), .SOFT_RST(SOFT_RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_BANK(CMD_BANK), .SAFE(SAFE), .BANKSEL(BANKSEL), .CUR_MODE(CUR_MODE),
    .CUR_BANK(CUR_BANK), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  chipram_bank_sequencer #(.NUMBANKS(8), .DEAD_CYCLES(2), .SAFE_TIMEOUT(8)) dut8 (
    .CCK(CCK), .RST(RST), .SOFT_RST(SOFT_RST), .CMD_VALID(CMD_VALID), .CMD_READY(rdy8),
    .CMD_OP(CMD_OP), .CMD_BANK(CMD_BANK), .SAFE(SAFE), .BANKSEL(bsel8), .CUR_MODE(mode8),
    .CUR_BANK(bank8), .BUSY(busy8), .TIMEOUT_ERR(terr8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CCK);
    #1;
  endtask

  // Clock until idle, pulsing SAFE in loop cycle sdly; counts cycles and all-ones cycles.
  task automatic run_idle(input int sdly, output int n_cyc, output int n_ones);
    n_cyc  = 0;
    n_ones = 0;
    while (BUSY && n_cyc < 60) begin
      SAFE = (n_cyc == sdly);
      tick();
      n_cyc++;
      if (BANKSEL == 16'hFFFF) n_ones++;
    end
    SAFE = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] bank, input int sdly,
                        output int n_cyc, output int n_ones);
    int k = 0;
    while (!CMD_READY && k < 50) begin
      tick();
      k++;
    end
    chk("ready_wait", 32'(CMD_READY), 32'd1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_BANK  = bank;
    tick();
    CMD_VALID = 1'b0;
    run_idle(sdly, n_cyc, n_ones);
  endtask

  // Break-before-make: at most one select low in either instance, every cycle.
  always @(negedge CCK) begin
    if (!RST) begin
      chk("onehot16", 32'($countones(~BANKSEL) <= 1), 32'd1);
      chk("onehot8",  32'($countones(~bsel8) <= 1), 32'd1);
    end
  end

  initial begin
    RST = 1'b1; SOFT_RST = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_BANK = 4'd0; SAFE = 1'b0;
    repeat (3) tick();
    chk("rst_bsel",  32'(BANKSEL), 32'hFFFF);
    chk("rst_mode",  32'(CUR_MODE), 32'd0);
    chk("rst_bank",  32'(CUR_BANK), 32'd0);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_terr",  32'(TIMEOUT_ERR), 32'd0);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_ready", 32'(CMD_READY), 32'd1);

    // CN bank 3, SAFE sampled on the 4th edge after accept
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_BANK = 4'd3;
    tick();
    CMD_VALID = 1'b0;
    chk("acc_busy",  32'(BUSY), 32'd1);
    chk("acc_ready", 32'(CMD_READY), 32'd0);
    repeat (3) tick();
    SAFE = 1'b1;
    tick();
    SAFE = 1'b0;
    chk("brk_bsel", 32'(BANKSEL), 32'hFFFF);
    chk("brk_mode", 32'(CUR_MODE), 32'd1);
    chk("brk_bank", 32'(CUR_BANK), 32'd3);
    tick();
    chk("brk2_bsel", 32'(BANKSEL), 32'hFFFF);
    tick();
    chk("mk_bsel",  32'(BANKSEL), 32'hFFF7);
    chk("mk_ready", 32'(CMD_READY), 32'd0);
    tick();
    chk("idle_ready", 32'(CMD_READY), 32'd1);
    chk("idle_busy",  32'(BUSY), 32'd0);
    chk("idle_bsel",  32'(BANKSEL), 32'hFFF7);

    // CN 3 -> CN 5 with SAFE in the first wait cycle
    do_cmd(2'b01, 4'd5, 0, nc, no);
    chk("sw_ones", 32'(no), 32'd2);
    chk("sw_cyc",  32'(nc), 32'd4);
    chk("sw_bsel", 32'(BANKSEL), 32'hFFDF);

    // SAFE coincides with the timeout cycle: clean switch
    do_cmd(2'b01, 4'd7, 7, nc, no);
    chk("tie_cyc",  32'(nc), 32'd11);
    chk("tie_terr", 32'(TIMEOUT_ERR), 32'd0);
    chk("tie_bsel", 32'(BANKSEL), 32'hFF7F);

    // No SAFE: forced after 8 wait cycles
    do_cmd(2'b10, 4'd2, 99, nc, no);
    chk("to_cyc",  32'(nc), 32'd11);
    chk("to_ones", 32'(no), 32'd2);
    chk("to_terr", 32'(TIMEOUT_ERR), 32'd1);
    chk("to_bsel", 32'(BANKSEL), 32'hFFFB);
    chk("to_mode", 32'(CUR_MODE), 32'd2);

    // Soft reset with RP bank: no effect
    SOFT_RST = 1'b1;
    tick();
    chk("srp_ready", 32'(CMD_READY), 32'd0);
    chk("srp_busy",  32'(BUSY), 32'd0);
    tick();
    SOFT_RST = 1'b0;
    repeat (3) tick();
    chk("srp_bsel", 32'(BANKSEL), 32'hFFFB);
    chk("srp_mode", 32'(CUR_MODE), 32'd2);

    // Soft reset with CN bank: internal disconnect
    do_cmd(2'b01, 4'd2, 0, nc, no);
    chk("cn2_bsel", 32'(BANKSEL), 32'hFFFB);
    SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    chk("scn_busy", 32'(BUSY), 32'd1);
    run_idle(0, nc, no);
    chk("scn_cyc",  32'(nc), 32'd3);
    chk("scn_bsel", 32'(BANKSEL), 32'hFFFF);
    chk("scn_mode", 32'(CUR_MODE), 32'd0);
    chk("scn_bank", 32'(CUR_BANK), 32'd2);

    // Soft reset during an RP command: bank kept
    CMD_VALID = 1'b1; CMD_OP = 2'b10; CMD_BANK = 4'd2;
    tick();
    CMD_VALID = 1'b0;
    SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    run_idle(0, nc, no);
    repeat (2) tick();
    chk("rpm_bsel", 32'(BANKSEL), 32'hFFFB);
    chk("rpm_busy", 32'(BUSY), 32'd0);
    chk("rpm_mode", 32'(CUR_MODE), 32'd2);

    // Soft reset during a CN command: bank dropped after it commits
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_BANK = 4'd4;
    tick();
    CMD_VALID = 1'b0;
    SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    run_idle(0, nc, no);
    chk("cnm_bsel", 32'(BANKSEL), 32'hFFEF);
    tick();
    chk("cnm_busy", 32'(BUSY), 32'd1);
    run_idle(0, nc, no);
    chk("cnm_drop_bsel", 32'(BANKSEL), 32'hFFFF);
    chk("cnm_drop_mode", 32'(CUR_MODE), 32'd0);

    // Repeated identical CN command is a no-op
    do_cmd(2'b01, 4'd6, 0, nc, no);
    chk("cn6_bsel", 32'(BANKSEL), 32'hFFBF);
    do_cmd(2'b01, 4'd6, 0, nc, no);
    chk("same_cyc",   32'(nc), 32'd0);
    chk("same_bsel",  32'(BANKSEL), 32'hFFBF);
    chk("same_ready", 32'(CMD_READY), 32'd1);
    chk("terr_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // Bank 12: valid for 16 banks, disconnect for 8 banks
    do_cmd(2'b01, 4'd12, 0, nc, no);
    chk("b12_bsel", 32'(BANKSEL), 32'hEFFF);
    chk("b12_mode", 32'(CUR_MODE), 32'd1);
    chk("n8_bsel",  32'(bsel8), 32'hFF);
    chk("n8_mode",  32'(mode8), 32'd0);
    chk("n8_bank",  32'(bank8), 32'd6);

    // Op 11 executes as disconnect
    do_cmd(2'b11, 4'd5, 0, nc, no);
    chk("op3_cyc",  32'(nc), 32'd3);
    chk("op3_bsel", 32'(BANKSEL), 32'hFFFF);
    chk("op3_mode", 32'(CUR_MODE), 32'd0);
    chk("op3_bank", 32'(CUR_BANK), 32'd12);

    // RST in the middle of MAKE
    CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_BANK = 4'd3;
    tick();
    CMD_VALID = 1'b0;
    SAFE = 1'b1;
    tick();
    SAFE = 1'b0;
    repeat (2) tick();
    chk("rmk_bsel", 32'(BANKSEL), 32'hFFF7);
    chk("rmk_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();
    chk("rr_bsel",  32'(BANKSEL), 32'hFFFF);
    chk("rr_mode",  32'(CUR_MODE), 32'd0);
    chk("rr_busy",  32'(BUSY), 32'd0);
    chk("rr_terr",  32'(TIMEOUT_ERR), 32'd0);
    chk("rr_ready", 32'(CMD_READY), 32'd0);
    repeat (2) tick();
    RST = 1'b0;
    tick();
    chk("rr_ready2", 32'(CMD_READY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
